// File: rtl/ram_cmd_arbiter_if.sv
// ram_cmd_arbiter_if
//   Bundles the two requester ports and the RAM command/response port of
//   ram_cmd_arbiter.
//   master : requesters + RAM model (drives req/we/addr/wdata, ram_dout,
//            ram_tx_valid; observes ack/rdata/err/busy, ram_din, ram_rx_valid)
//   slave  : the arbiter itself
interface ram_cmd_arbiter_if #(
    parameter int ADDR_SIZE = 8
);
    logic                 req0, req1;
    logic                 we0, we1;
    logic [ADDR_SIZE-1:0] addr0, addr1;
    logic [ADDR_SIZE-1:0] wdata0, wdata1;
    logic                 ack0, ack1;
    logic [ADDR_SIZE-1:0] rdata;
    logic                 err;
    logic                 busy;
    logic [ADDR_SIZE+1:0] ram_din;
    logic                 ram_rx_valid;
    logic [ADDR_SIZE-1:0] ram_dout;
    logic                 ram_tx_valid;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output ram_dout, ram_tx_valid,
        input  ack0, ack1, rdata, err, busy, ram_din, ram_rx_valid
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  ram_dout, ram_tx_valid,
        output ack0, ack1, rdata, err, busy, ram_din, ram_rx_valid
    );
endinterface

// File: rtl/ram_cmd_arbiter.sv
// ram_cmd_arbiter
//   Round-robin arbiter between two requesters sharing one RAM command port.
//   Each granted transaction sends two command words ({opcode, payload}):
//   address word (00 = write addr, 10 = read addr) then data word
//   (01 = write data, 11 = read trigger). Reads wait for ram_tx_valid.
//   Ports: clk, rst (async, active-high), bus (ram_cmd_arbiter_if.slave).
//   Optional feature: define RAM_ARB_TIMEOUT_EN to abandon a read after
//   TIMEOUT cycles in WAIT_RD, completing it with ack + err and leaving
//   rdata untouched. Without it err is tied low and reads wait forever.
module ram_cmd_arbiter #(
    parameter int ADDR_SIZE = 8,
    parameter int TIMEOUT   = 8
) (
    input  logic             clk,
    input  logic             rst,
    ram_cmd_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CMD_ADDR, CMD_DATA, WAIT_RD, DONE} state_t;

    if (TIMEOUT < 1) begin : g_timeout_chk
        $error("ram_cmd_arbiter: TIMEOUT must be at least 1");
    end

    state_t               state_q, state_d;
    logic                 gnt_q, gnt_d;     // requester owning the current transaction
    logic                 last_q, last_d;   // requester granted most recently
    logic                 we_q, we_d;
    logic [ADDR_SIZE-1:0] addr_q, addr_d;
    logic [ADDR_SIZE-1:0] wdata_q, wdata_d;
    logic [ADDR_SIZE-1:0] rdata_q, rdata_d;

`ifdef RAM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             to_q, to_d;           // current read ended by timeout
`endif

    always_comb begin
        state_d          = state_q;
        gnt_d            = gnt_q;
        last_d           = last_q;
        we_d             = we_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        rdata_d          = rdata_q;
        bus.ram_rx_valid = 1'b0;
        bus.ram_din      = '0;
        bus.ack0         = 1'b0;
        bus.ack1         = 1'b0;
`ifdef RAM_ARB_TIMEOUT_EN
        cnt_d            = cnt_q;
        to_d             = to_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    // On a tie the requester not served last wins.
                    gnt_d   = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
                    last_d  = gnt_d;
                    we_d    = gnt_d ? bus.we1    : bus.we0;
                    addr_d  = gnt_d ? bus.addr1  : bus.addr0;
                    wdata_d = gnt_d ? bus.wdata1 : bus.wdata0;
                    state_d = CMD_ADDR;
`ifdef RAM_ARB_TIMEOUT_EN
                    to_d    = 1'b0;
`endif
                end
            end
            CMD_ADDR: begin
                bus.ram_rx_valid = 1'b1;
                bus.ram_din      = {(we_q ? 2'b00 : 2'b10), addr_q};
                state_d          = CMD_DATA;
            end
            CMD_DATA: begin
                bus.ram_rx_valid = 1'b1;
                bus.ram_din      = we_q ? {2'b01, wdata_q} : {2'b11, {ADDR_SIZE{1'b0}}};
                state_d          = we_q ? DONE : WAIT_RD;
`ifdef RAM_ARB_TIMEOUT_EN
                cnt_d            = '0;
`endif
            end
            WAIT_RD: begin
                if (bus.ram_tx_valid) begin
                    rdata_d = bus.ram_dout;
                    state_d = DONE;
                end
`ifdef RAM_ARB_TIMEOUT_EN
                // cnt_q counts completed WAIT_RD cycles; leave after TIMEOUT of them.
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    to_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            DONE: begin
                bus.ack0 = ~gnt_q;
                bus.ack1 = gnt_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef RAM_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            to_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef RAM_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            to_q    <= to_d;
`endif
        end
    end

    assign bus.busy  = (state_q != IDLE);
    assign bus.rdata = rdata_q;
`ifdef RAM_ARB_TIMEOUT_EN
    assign bus.err   = (state_q == DONE) && to_q;
`else
    assign bus.err   = 1'b0;
`endif
endmodule
